// File: rtl/clk_rst_pkg.sv
// Shared definitions for the divided-clock reset/start-up sequencer.
package clk_rst_pkg;

  localparam int STATE_W = 3;

  // Encodings are exposed on seq_state for debug/CSR readback, so they are fixed.
  typedef enum logic [STATE_W-1:0] {
    ST_RST       = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_HOLD      = 3'd2,
    ST_RUN       = 3'd3,
    ST_SLEEP     = 3'd4
  } seq_state_e;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_HOLD_CYCLES = 16;
  localparam int DEF_CNT_W       = 8;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer: 1-bit, parameterized depth, async active-high clear to 0.
module sync_ff
  import clk_rst_pkg::*;
#(
  parameter int DEPTH = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] stage_reg;

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      // First flop samples the asynchronous input.
      always_ff @(posedge clk or posedge clr) begin
        if (clr) stage_reg[0] <= 1'b0;
        else     stage_reg[0] <= d;
      end
    end else begin : g_rest
      // Following flops give metastability time to resolve.
      always_ff @(posedge clk or posedge clr) begin
        if (clr) stage_reg[gi] <= 1'b0;
        else     stage_reg[gi] <= stage_reg[gi-1];
      end
    end
  end

  assign q = stage_reg[DEPTH-1];

endmodule

// File: rtl/clk_domain_rst_seq.sv
// Reset/start-up sequencer for the divided processor clock domain.
// Releases the core from reset a fixed number of cycles after PLL lock,
// offers a four-phase sleep handshake and re-sequences on lock loss.
module clk_domain_rst_seq
  import clk_rst_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pll_lock,
  input  logic               sleep_req,
  output logic               core_rst,
  output logic               core_clk_en,
  output logic               sleep_ack,
  output logic [STATE_W-1:0] seq_state
);

  // Reject parameter sets that cannot work at elaboration time.
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("clk_domain_rst_seq: SYNC_STAGES must be >= 2");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold_cycles
    $error("clk_domain_rst_seq: HOLD_CYCLES must be >= 1");
  end
  if ((64'd1 << CNT_W) <= 64'(HOLD_CYCLES)) begin : g_bad_cnt_w
    $error("clk_domain_rst_seq: CNT_W too narrow for HOLD_CYCLES");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  logic             rst_s;
  logic             lock_s;
  seq_state_e       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             core_rst_reg, core_clk_en_reg, sleep_ack_reg;

  // Reset release: a constant 1 shifts in once reset deasserts.
  sync_ff #(.DEPTH(SYNC_STAGES)) u_rst_sync (
    .clk (clk),
    .clr (reset),
    .d   (1'b1),
    .q   (rst_s)
  );

  // PLL lock flag brought into the clk domain.
  sync_ff #(.DEPTH(SYNC_STAGES)) u_lock_sync (
    .clk (clk),
    .clr (reset),
    .d   (pll_lock),
    .q   (lock_s)
  );

  // Next-state and hold-counter logic; lock loss always has top priority.
  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    case (state_reg)
      ST_RST: begin
        if (rst_s) state_next = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s) state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (!lock_s)                 state_next = ST_WAIT_LOCK;
        else if (cnt_reg == CNT_LAST) state_next = ST_RUN;
        else                          cnt_next   = cnt_reg + CNT_W'(1);
      end
      ST_RUN: begin
        if (!lock_s)        state_next = ST_WAIT_LOCK;
        else if (sleep_req) state_next = ST_SLEEP;
      end
      ST_SLEEP: begin
        if (!lock_s)         state_next = ST_WAIT_LOCK;
        else if (!sleep_req) state_next = ST_RUN;
      end
      default: state_next = ST_RST;
    endcase
  end

  // State, counter and outputs; outputs decode the next state so they move with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_RST;
      cnt_reg         <= '0;
      core_rst_reg    <= 1'b1;
      core_clk_en_reg <= 1'b0;
      sleep_ack_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      core_rst_reg    <= !((state_next == ST_RUN) || (state_next == ST_SLEEP));
      core_clk_en_reg <= (state_next == ST_RUN);
      sleep_ack_reg   <= (state_next == ST_SLEEP);
    end
  end

  assign core_rst    = core_rst_reg;
  assign core_clk_en = core_clk_en_reg;
  assign sleep_ack   = sleep_ack_reg;
  assign seq_state   = state_reg;

endmodule
